ram_seq_ctrl: RTL
=================

Name: ram_seq_ctrl

Overview:
Command sequencer that drives the team's 8x8 synchronous `ram` block from its port side. It accepts single or burst read/write commands over a valid/ready handshake and generates the `adr`/`dIn`/`writeEn` sequence. It accounts for the RAM's one-cycle registered read, where `dOut` updates only on cycles with `writeEn` low, and returns read data as a response stream. It sits between a host/test FSM and the RAM instance.

Parameters:
- ADR_W, 3, RAM address width; depth = 2**ADR_W.
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmdValid  in  1  command offered.
- cmdReady  out  1  controller can accept a command; high only in IDLE.
- cmdWrite  in  1  1 = write, 0 = read.
- cmdAdr  in  ADR_W  start address.
- cmdData  in  DATA_W  write seed data; ignored for reads.
- cmdLen  in  ADR_W  burst length minus 1 (0 = single access, 7 = full memory).
- rspValid  out  1  one-cycle pulse per read beat; no back-pressure.
- rspData  out  DATA_W  read data.
- rspAdr  out  ADR_W  address the rspData came from.
- rspLast  out  1  qualifies the final beat of a read burst.
- done  out  1  one-cycle pulse when a command fully completes.
- ramAdr  out  ADR_W  to ram adr.
- ramDIn  out  DATA_W  to ram dIn.
- ramWriteEn  out  1  to ram writeEn.
- ramDOut  in  DATA_W  from ram dOut.

Behaviour:
- Outputs: all registered. Reset values are 0 for cmdReady, rspValid, rspData, rspAdr, rspLast, done, ramAdr, ramDIn and ramWriteEn; state = IDLE. cmdReady rises the first cycle after reset release.
- Handshake: accept on a clock edge where cmdValid && cmdReady. The command fields are sampled at that edge and are don't-care afterwards.
- States: IDLE, WR, RD, FLUSH.
- IDLE:
  - cmdReady=1, ramWriteEn=0, ramAdr holds its last value.
  - Accept with cmdWrite=1 goes to WR; accept with cmdWrite=0 goes to RD.
- WR, beat i = 0..cmdLen:
  - ramWriteEn=1, ramAdr=(cmdAdr+i) mod 2**ADR_W, ramDIn=(cmdData+i) mod 2**DATA_W.
  - Beat 0 is driven the cycle right after the accept edge; one beat per cycle, no gaps.
  - After the last beat: ramWriteEn=0, done pulses in the same cycle, state returns to IDLE.
  - A read accepted immediately after a write observes the written data.
- RD, beat i:
  - ramWriteEn=0, ramAdr=(cmdAdr+i) mod depth, one beat per cycle.
  - A 2-deep valid/address tag pipeline tracks in-flight beats.
  - The RAM registers dOut one edge after the address is presented; the controller registers rspData from ramDOut one edge later.
  - Latency: the first rspValid appears 2 cycles after the cycle ramAdr is first driven, i.e. in the 3rd cycle after the accept edge. Beats are then back-to-back.
- FLUSH:
  - Entered after the last read address; ramWriteEn stays 0.
  - Remains until the tag pipeline is empty.
  - rspLast and done pulse together with the final rspValid; the state returns to IDLE on the next cycle.
- Wrap-around: address arithmetic wraps modulo depth, so cmdAdr=6, cmdLen=3 visits 6,7,0,1. Data arithmetic wraps modulo 2**DATA_W.
- cmdLen=7 from any start address covers each location exactly once.
- cmdValid while busy: ignored (cmdReady=0); no queuing.
- Reset mid-operation: the asynchronous reset immediately forces ramWriteEn=0, rspValid=0 and done=0, and clears the pipeline. Pending beats are dropped and no partial response is emitted. RAM contents are not cleared.

Decomposition:
- Package ram_seq_pkg:
  - state enum (IDLE, WR, RD, FLUSH);
  - ADR_W/DATA_W defaults;
  - a command struct {write, adr, data, len}.
- One sub-module, ram_rd_pipe: the 2-stage valid/address/last tag pipeline producing rspValid, rspAdr and rspLast, and capturing rspData.
- The bench instantiates ram_seq_ctrl wired to the existing ram block.

Test Plan:
- Reset, then single write adr=3 data=0xA5 -> ramWriteEn high exactly 1 cycle with ramAdr=3, ramDIn=0xA5; done pulses; cmdReady back high the next cycle.
- Single read adr=3 accepted right after that write -> exactly one rspValid, 3 cycles after accept, with rspData=0xA5, rspAdr=3, rspLast=1, done=1.
- Burst write adr=6 len=3 data=0xFE -> writes (6,0xFE),(7,0xFF),(0,0x00),(1,0x01) on 4 consecutive cycles. Burst read adr=6 len=3 -> 4 back-to-back responses with the same pairs, rspLast only on adr=1.
- Full fill adr=0 len=7 data=0x10, then full read adr=5 len=7 -> 8 beats: addresses 5,6,7,0..4 with data 0x15,0x16,0x17,0x10..0x14.
- cmdValid held high during a burst read -> no second accept until cmdReady; the second command starts only after the first command's done.
- Assert rst during the 2nd beat of a 4-beat read -> outputs zero immediately, no further rspValid. After release, a single read of a previously written address returns correct data.

Source files
------------

// File: rtl/ram_seq_pkg.sv
// ram_seq_pkg
// Shared types and defaults for the RAM command sequencer slice.
//   ADR_W_DEF / DATA_W_DEF : geometry of the team's 8x8 ram block
//   state_t                : sequencer states
//   cmd_t                  : one host command as sampled at the accept edge
package ram_seq_pkg;

  localparam int ADR_W_DEF  = 3;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    FLUSH
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADR_W_DEF-1:0]  adr;
    logic [DATA_W_DEF-1:0] data;
    logic [ADR_W_DEF-1:0]  len;
  } cmd_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe
// Two-stage tag pipeline that follows read beats through the ram's
// registered read and turns them into the response stream.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   issueValid      a read address is on ramAdr this cycle
//   issueAdr        that address
//   issueLast       it is the final address of the burst
//   ramDOut         ram read data (valid one edge after the address)
//   s1Last          stage-1 tag says the final beat lands next edge
//   rspValid/rspData/rspAdr/rspLast  registered response beat
module ram_rd_pipe
  import ram_seq_pkg::*;
#(
  parameter int ADR_W  = ADR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issueValid,
  input  logic [ADR_W-1:0]  issueAdr,
  input  logic              issueLast,
  input  logic [DATA_W-1:0] ramDOut,
  output logic              s1Last,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic [ADR_W-1:0]  rspAdr,
  output logic              rspLast
);

  logic             s1Valid;
  logic [ADR_W-1:0] s1Adr;

  // Stage 1 mirrors the edge at which the ram latches dOut for the
  // address issued this cycle; stage 2 captures that dOut together with
  // its tag, so rspData always lines up with rspAdr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid  <= 1'b0;
      s1Adr    <= '0;
      s1Last   <= 1'b0;
      rspValid <= 1'b0;
      rspData  <= '0;
      rspAdr   <= '0;
      rspLast  <= 1'b0;
    end else begin
      s1Valid  <= issueValid;
      s1Adr    <= issueAdr;
      s1Last   <= issueValid & issueLast;
      rspValid <= s1Valid;
      rspLast  <= s1Valid & s1Last;
      if (s1Valid) begin
        rspData <= ramDOut;
        rspAdr  <= s1Adr;
      end
    end
  end

endmodule

// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl
// Command sequencer driving the 8x8 synchronous ram from its port side.
// Accepts single/burst read and write commands over valid/ready and
// returns read data as a response stream. All outputs are registered.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmdValid/cmdReady              command handshake (ready only in IDLE)
//   cmdWrite/cmdAdr/cmdData/cmdLen command fields (len = beats - 1)
//   rspValid/rspData/rspAdr/rspLast read response beat
//   done                           pulse when a command completes
//   ramAdr/ramDIn/ramWriteEn       to the ram
//   ramDOut                        from the ram
module ram_seq_ctrl
  import ram_seq_pkg::*;
#(
  parameter int ADR_W  = ADR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic              cmdWrite,
  input  logic [ADR_W-1:0]  cmdAdr,
  input  logic [DATA_W-1:0] cmdData,
  input  logic [ADR_W-1:0]  cmdLen,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic [ADR_W-1:0]  rspAdr,
  output logic              rspLast,
  output logic              done,
  output logic [ADR_W-1:0]  ramAdr,
  output logic [DATA_W-1:0] ramDIn,
  output logic              ramWriteEn,
  input  logic [DATA_W-1:0] ramDOut
);

  state_t state, stateNext;

  cmd_t cmd;

  logic [ADR_W-1:0]  remain, remainNext;
  logic [ADR_W-1:0]  ramAdrNext;
  logic [DATA_W-1:0] ramDInNext;
  logic              ramWriteEnNext;
  logic              cmdReadyNext;
  logic              doneNext;

  logic              issueValid;
  logic              issueLast;
  logic              s1Last;

  assign cmd.write = cmdWrite;
  assign cmd.adr   = cmdAdr;
  assign cmd.data  = cmdData;
  assign cmd.len   = cmdLen;

  // A read beat is in flight whenever the RD state is presenting an
  // address; the beat is the last one once the remaining count is zero.
  assign issueValid = (state == RD);
  assign issueLast  = (state == RD) && (remain == '0);

  ram_rd_pipe #(
    .ADR_W (ADR_W),
    .DATA_W(DATA_W)
  ) uRdPipe (
    .clk       (clk),
    .rst       (rst),
    .issueValid(issueValid),
    .issueAdr  (ramAdr),
    .issueLast (issueLast),
    .ramDOut   (ramDOut),
    .s1Last    (s1Last),
    .rspValid  (rspValid),
    .rspData   (rspData),
    .rspAdr    (rspAdr),
    .rspLast   (rspLast)
  );

  // Next-state and next-output logic. Every output is computed one cycle
  // ahead and registered, so beat 0 of a command appears the cycle after
  // the accept edge. remain counts beats still to be issued after the
  // one currently on the ram port.
  always_comb begin
    stateNext      = state;
    remainNext     = remain;
    ramAdrNext     = ramAdr;
    ramDInNext     = ramDIn;
    ramWriteEnNext = 1'b0;
    doneNext       = s1Last;
    cmdReadyNext   = 1'b0;

    case (state)
      IDLE: begin
        if (cmdValid && cmdReady) begin
          ramAdrNext = cmd.adr;
          remainNext = cmd.len;
          if (cmd.write) begin
            stateNext      = WR;
            ramWriteEnNext = 1'b1;
            ramDInNext     = cmd.data;
          end else begin
            stateNext = RD;
          end
        end
      end

      WR: begin
        if (remain == '0) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end else begin
          ramWriteEnNext = 1'b1;
          ramAdrNext     = ramAdr + 1'b1;
          ramDInNext     = ramDIn + 1'b1;
          remainNext     = remain - 1'b1;
        end
      end

      RD: begin
        if (remain == '0) begin
          stateNext = FLUSH;
        end else begin
          ramAdrNext = ramAdr + 1'b1;
          remainNext = remain - 1'b1;
        end
      end

      FLUSH: begin
        // The final beat has just been presented with done; leave now.
        if (rspLast) begin
          stateNext = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase

    cmdReadyNext = (stateNext == IDLE);
  end

  // Registered state and ram-side outputs; reset holds cmdReady low so
  // the first accept can only happen after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      remain     <= '0;
      ramAdr     <= '0;
      ramDIn     <= '0;
      ramWriteEn <= 1'b0;
      cmdReady   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= stateNext;
      remain     <= remainNext;
      ramAdr     <= ramAdrNext;
      ramDIn     <= ramDInNext;
      ramWriteEn <= ramWriteEnNext;
      cmdReady   <= cmdReadyNext;
      done       <= doneNext;
    end
  end

endmodule
